// File: rtl/tx_frame_scheduler.sv
// Round-robin scheduler sharing one 802.11a transmitter between two bit-serial frame sources.
// Optional per-requester completed-frame counters are enabled with `define FRAME_CNT_EN.
module tx_frame_scheduler #(
    parameter int LEN_W      = 12,
    parameter int GAP_CYCLES = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Req0,
    input  logic [LEN_W-1:0] Len0,
    input  logic             Data0,
    output logic             Grant0,
    output logic             Ready0,
    input  logic             Req1,
    input  logic [LEN_W-1:0] Len1,
    input  logic             Data1,
    output logic             Grant1,
    output logic             Ready1,
    output logic             TxStart,
    output logic             TxInput,
    output logic             Busy,
`ifdef FRAME_CNT_EN
    output logic [15:0]      FrameCnt0,
    output logic [15:0]      FrameCnt1,
`endif
    output logic             LenErr
);

    // The gap counter loads max(GAP_CYCLES,1)-1 and counts down to zero.
    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 1) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_STREAM = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
    logic             ptr, ptr_nxt;
    logic             gsel, gsel_nxt;
    logic             grant0_q, grant0_nxt;
    logic             grant1_q, grant1_nxt;
    logic             tx_start_q, tx_start_nxt;
    logic             len_err_q, len_err_nxt;
    logic             pick;
    logic [LEN_W-1:0] pick_len;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            ptr        <= 1'b0;
            gsel       <= 1'b0;
            grant0_q   <= 1'b0;
            grant1_q   <= 1'b0;
            tx_start_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            ptr        <= ptr_nxt;
            gsel       <= gsel_nxt;
            grant0_q   <= grant0_nxt;
            grant1_q   <= grant1_nxt;
            tx_start_q <= tx_start_nxt;
            len_err_q  <= len_err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        gap_cnt_nxt  = gap_cnt;
        ptr_nxt      = ptr;
        gsel_nxt     = gsel;
        grant0_nxt   = 1'b0;
        grant1_nxt   = 1'b0;
        tx_start_nxt = 1'b0;
        len_err_nxt  = 1'b0;
        pick         = 1'b0;
        pick_len     = '0;
        case (state)
            S_IDLE: begin
                if (Req0 || Req1) begin
                    pick        = (Req0 && Req1) ? ptr : Req1;
                    pick_len    = pick ? Len1 : Len0;
                    gsel_nxt    = pick;
                    ptr_nxt     = ~pick;
                    bit_cnt_nxt = pick_len;
                    grant0_nxt  = ~pick;
                    grant1_nxt  = pick;
                    if (pick_len != '0) begin
                        state_nxt    = S_START;
                        tx_start_nxt = 1'b1;
                    end else begin
                        // Zero-length grant skips the transmitter entirely.
                        state_nxt   = S_GAP;
                        len_err_nxt = 1'b1;
                        gap_cnt_nxt = GAP_LOAD;
                    end
                end
            end
            S_START: state_nxt = S_STREAM;
            S_STREAM: begin
                bit_cnt_nxt = bit_cnt - LEN_ONE;
                if (bit_cnt == LEN_ONE) begin
                    state_nxt   = S_GAP;
                    gap_cnt_nxt = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) state_nxt = S_IDLE;
                else gap_cnt_nxt = gap_cnt - GAP_ONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef FRAME_CNT_EN
    logic frame_done;
    assign frame_done = (state == S_STREAM) && (bit_cnt == LEN_ONE);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            FrameCnt0 <= 16'd0;
            FrameCnt1 <= 16'd0;
        end else if (frame_done) begin
            if (gsel) FrameCnt1 <= FrameCnt1 + 16'd1;
            else      FrameCnt0 <= FrameCnt0 + 16'd1;
        end
    end
`endif

    assign Grant0  = grant0_q;
    assign Grant1  = grant1_q;
    assign TxStart = tx_start_q;
    assign LenErr  = len_err_q;
    assign Busy    = (state != S_IDLE);
    assign Ready0  = (state == S_STREAM) && !gsel;
    assign Ready1  = (state == S_STREAM) && gsel;
    assign TxInput = (state == S_STREAM) && (gsel ? Data1 : Data0);

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Randomized scoreboard bench for tx_frame_scheduler: requester models feed frames,
// a round-robin transaction model predicts grant order and bits, a monitor checks them.
module tb_tx_frame_scheduler;
    localparam int LEN_W = 12;
    localparam int GAP   = 16;
    localparam int GAPN  = (GAP < 1) ? 1 : GAP;
    localparam int EXP_W = LEN_W + 1;

    logic Clock, Reset;
    logic Req0, Req1, Data0, Data1;
    logic [LEN_W-1:0] Len0, Len1;
    logic Grant0, Grant1, Ready0, Ready1, TxStart, TxInput, Busy, LenErr;
`ifdef FRAME_CNT_EN
    logic [15:0] FrameCnt0, FrameCnt1;
`endif

    tx_frame_scheduler #(.LEN_W(LEN_W), .GAP_CYCLES(GAP)) dut (
        .Clock(Clock), .Reset(Reset),
        .Req0(Req0), .Len0(Len0), .Data0(Data0), .Grant0(Grant0), .Ready0(Ready0),
        .Req1(Req1), .Len1(Len1), .Data1(Data1), .Grant1(Grant1), .Ready1(Ready1),
        .TxStart(TxStart), .TxInput(TxInput), .Busy(Busy),
`ifdef FRAME_CNT_EN
        .FrameCnt0(FrameCnt0), .FrameCnt1(FrameCnt1),
`endif
        .LenErr(LenErr)
    );

    // clock / reset
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int checks = 0;
    int failures = 0;

    // scoreboard: expected grants {index, length} and expected serial bits
    logic [EXP_W-1:0] exp_q[$];
    logic             exp_bit_q[$];
    int   stg_len0[$], stg_len1[$];
    int   fr_len_q0[$], fr_len_q1[$];
    logic bit_q0[$], bit_q1[$];
    bit   ptr_model = 1'b0;
    bit   mon_en = 1'b0;
    int   fc_model0 = 0, fc_model1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=event t=%0t", name, $time);
    endtask

    // Round-robin transaction model: both requesters pending alternate, starting at the pointer.
    task automatic issue_batch();
        logic b0[$];
        logic b1[$];
        logic b;
        int i0, i1, g, l;
        i0 = 0;
        i1 = 0;
        foreach (stg_len0[k]) begin
            fr_len_q0.push_back(stg_len0[k]);
            for (int j = 0; j < stg_len0[k]; j++) begin
                b = 1'($urandom_range(0, 1));
                bit_q0.push_back(b);
                b0.push_back(b);
            end
        end
        foreach (stg_len1[k]) begin
            fr_len_q1.push_back(stg_len1[k]);
            for (int j = 0; j < stg_len1[k]; j++) begin
                b = 1'($urandom_range(0, 1));
                bit_q1.push_back(b);
                b1.push_back(b);
            end
        end
        while (i0 < stg_len0.size() || i1 < stg_len1.size()) begin
            if (i0 < stg_len0.size() && i1 < stg_len1.size()) g = ptr_model ? 1 : 0;
            else g = (i1 < stg_len1.size()) ? 1 : 0;
            if (g == 1) begin
                l = stg_len1[i1];
                i1++;
            end else begin
                l = stg_len0[i0];
                i0++;
            end
            exp_q.push_back({1'(g), LEN_W'(l)});
            for (int j = 0; j < l; j++) exp_bit_q.push_back(g == 1 ? b1.pop_front() : b0.pop_front());
            if (l != 0) begin
                if (g == 1) fc_model1++;
                else fc_model0++;
            end
            ptr_model = (g == 0);
        end
        stg_len0.delete();
        stg_len1.delete();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 20000 && (exp_q.size() != 0 || fr_len_q0.size() != 0 ||
                             fr_len_q1.size() != 0 || Busy)) begin
            @(negedge Clock);
            n++;
        end
        if (n >= 20000) fail_now("idle_timeout");
        repeat (2) @(negedge Clock);
`ifdef FRAME_CNT_EN
        chk("frame_cnt0", FrameCnt0, fc_model0[15:0]);
        chk("frame_cnt1", FrameCnt1, fc_model1[15:0]);
`endif
        #2;
    endtask

    // requester models: hold Req while frames are queued, consume a bit on each Ready
    initial begin : requesters
        bit g0, g1, r0, r1;
        Req0 = 1'b0; Req1 = 1'b0; Data0 = 1'b0; Data1 = 1'b0; Len0 = '0; Len1 = '0;
        forever begin
            @(negedge Clock);
            g0 = Grant0; g1 = Grant1; r0 = Ready0; r1 = Ready1;
            @(posedge Clock);
            #1;
            if (g0 && fr_len_q0.size() != 0) void'(fr_len_q0.pop_front());
            if (g1 && fr_len_q1.size() != 0) void'(fr_len_q1.pop_front());
            if (r0 && bit_q0.size() != 0) void'(bit_q0.pop_front());
            if (r1 && bit_q1.size() != 0) void'(bit_q1.pop_front());
            Req0  = (fr_len_q0.size() != 0);
            Req1  = (fr_len_q1.size() != 0);
            Len0  = (fr_len_q0.size() != 0) ? LEN_W'(fr_len_q0[0]) : '0;
            Len1  = (fr_len_q1.size() != 0) ? LEN_W'(fr_len_q1[0]) : '0;
            Data0 = (bit_q0.size() != 0) ? bit_q0[0] : 1'b0;
            Data1 = (bit_q1.size() != 0) ? bit_q1[0] : 1'b0;
        end
    end

    // Walks one granted frame: grant cycle, Len stream cycles, gap, then one idle cycle.
    task automatic walk_frame(output bit b2b);
        logic [EXP_W-1:0] e;
        logic eb;
        int eg, el, rem;
        b2b = 1'b0;
        if (exp_q.size() == 0) begin
            fail_now("unexpected_grant");
            return;
        end
        e  = exp_q.pop_front();
        eg = int'(e[LEN_W]);
        el = int'(e[LEN_W-1:0]);
        chk("grant_index", {Grant1, Grant0}, (eg == 1) ? 2'b10 : 2'b01);
        chk("tx_start", TxStart, (el != 0));
        chk("len_err", LenErr, (el == 0));
        chk("grant_cycle_io", {Busy, Ready1, Ready0, TxInput}, 4'b1000);
        if (el != 0) begin
            for (int i = 0; i < el; i++) begin
                @(negedge Clock);
                if (!mon_en) return;
                eb = 1'b0;
                if (exp_bit_q.size() != 0) eb = exp_bit_q.pop_front();
                chk("stream_ready", {Ready1, Ready0}, (eg == 1) ? 2'b10 : 2'b01);
                chk("stream_bit", TxInput, eb);
                chk("stream_ctrl", {Busy, Grant1, Grant0, TxStart, LenErr}, 5'b10000);
            end
        end
        rem = (el != 0) ? GAPN : GAPN - 1;
        for (int i = 0; i < rem; i++) begin
            @(negedge Clock);
            if (!mon_en) return;
            chk("gap", {Busy, Ready1, Ready0, TxInput, Grant1, Grant0, TxStart, LenErr}, 8'h80);
        end
        @(negedge Clock);
        if (!mon_en) return;
        chk("idle_after_gap", {Busy, Ready1, Ready0, TxInput}, 4'b0000);
        b2b = (exp_q.size() != 0);
    endtask

    initial begin : monitor
        bit b2b, got;
        int budget;
        b2b = 1'b0;
        forever begin
            wait (mon_en);
            budget = b2b ? 1 : 400;
            b2b = 1'b0;
            got = 1'b0;
            for (int i = 0; i < budget && mon_en; i++) begin
                @(negedge Clock);
                if (Grant0 || Grant1) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!mon_en) continue;
            if (!got) begin
                if (budget == 1) fail_now("back_to_back_grant");
                else if (exp_q.size() != 0) fail_now("grant_timeout");
                continue;
            end
            walk_frame(b2b);
        end
    end

    initial begin : driver
        int cnt;
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        chk("reset_outputs", {Busy, Grant0, Grant1, Ready0, Ready1, TxStart, TxInput, LenErr}, 8'h00);
`ifdef FRAME_CNT_EN
        chk("reset_frame_cnt", {FrameCnt0, FrameCnt1}, 32'd0);
`endif
        #2 Reset = 1'b0;
        @(negedge Clock);
        chk("idle_after_reset", {Busy, Grant0, Grant1, Ready0, Ready1, TxStart, TxInput, LenErr}, 8'h00);
        #2 mon_en = 1'b1;

        stg_len0.push_back(8);
        issue_batch();
        wait_idle();

        stg_len0 = '{4, 4};
        stg_len1 = '{4, 4};
        issue_batch();
        wait_idle();

        stg_len1.push_back(0);
        issue_batch();
        wait_idle();

        for (int r = 0; r < 8; r++) begin
            int n0, n1;
            n0 = $urandom_range(0, 2);
            n1 = $urandom_range(0, 2);
            if (n0 + n1 == 0) n0 = 1;
            for (int k = 0; k < n0; k++) stg_len0.push_back(($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 24));
            for (int k = 0; k < n1; k++) stg_len1.push_back(($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 24));
            issue_batch();
            wait_idle();
        end

        // reset in the middle of a 10-bit frame, after its third bit
        stg_len0.push_back(10);
        issue_batch();
        cnt = 0;
        for (int i = 0; i < 200 && cnt < 3; i++) begin
            @(negedge Clock);
            if (Ready0) cnt++;
        end
        if (cnt < 3) fail_now("reset_mid_wait");
        #2;
        mon_en = 1'b0;
        Reset = 1'b1;
        @(negedge Clock);
        chk("reset_mid_outputs", {Busy, Ready0, Ready1, TxInput, Grant0, Grant1, TxStart, LenErr}, 8'h00);
        #2;
        fr_len_q0.delete(); fr_len_q1.delete();
        bit_q0.delete(); bit_q1.delete();
        exp_q.delete(); exp_bit_q.delete();
        ptr_model = 1'b0;
        fc_model0 = 0;
        fc_model1 = 0;
        @(negedge Clock);
        #2 Reset = 1'b0;
        mon_en = 1'b1;

        // both pending right after reset: requester 0 must win
        stg_len0 = '{5, 5, 5};
        stg_len1 = '{0};
        issue_batch();
        wait_idle();

        stg_len0.push_back(4095);
        issue_batch();
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog actual=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
